// File: rtl/timer_core.sv
// rtl/timer_core.sv - cascaded BCD stopwatch/countdown core with adjust, pause, lap freeze and expiry
module timer_core #(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_MOD  = 60,
    parameter int SEL_W      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_en,
    input  logic                    adj_tick,
    input  logic                    pause_req,
    input  logic                    lap_req,
    input  logic                    clr,
    input  logic                    adj,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    down,
    output logic [8*NUM_FIELDS-1:0] digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    expired,
    output logic                    carry_out
);

    localparam int DW = 8 * NUM_FIELDS;
    localparam logic [3:0] MAX_TENS = 4'((FIELD_MOD - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((FIELD_MOD - 1) % 10);
    localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   snap_q, snap_d;
    logic            lap_q, lap_d;
    logic            carry_q, carry_d;

    logic [DW-1:0]   up_val, dn_val, adj_val;
    logic            all_max, all_zero, dn_zero;
    logic            up_c, dn_b;

    // One BCD field step up, wrapping FIELD_MOD-1 back to zero
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == MAX_BCD)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return v + 8'd1;
    endfunction

    // One BCD field step down, wrapping zero to FIELD_MOD-1
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return MAX_BCD;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return v - 8'd1;
    endfunction

    // Whole-count terminal detection for up wrap and countdown floor
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (cnt_q[8*i +: 8] != MAX_BCD) all_max  = 1'b0;
            if (cnt_q[8*i +: 8] != 8'h00)   all_zero = 1'b0;
        end
    end

    // Candidate counts: cascaded increment, cascaded decrement, single-field adjust
    always_comb begin
        up_val  = cnt_q;
        dn_val  = cnt_q;
        adj_val = cnt_q;
        up_c    = 1'b1;
        dn_b    = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (up_c) begin
                up_val[8*i +: 8] = bcd_inc(cnt_q[8*i +: 8]);
                up_c = (cnt_q[8*i +: 8] == MAX_BCD);
            end
            if (dn_b) begin
                dn_val[8*i +: 8] = bcd_dec(cnt_q[8*i +: 8]);
                dn_b = (cnt_q[8*i +: 8] == 8'h00);
            end
            if (int'(sel) == i)
                adj_val[8*i +: 8] = down ? bcd_dec(cnt_q[8*i +: 8]) : bcd_inc(cnt_q[8*i +: 8]);
        end
        dn_zero = (dn_val == '0);
    end

    // Next-state: clear, then adjust or count, then run/pause and lap toggles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        lap_d   = lap_q;
        carry_d = 1'b0;
        if (clr) begin
            cnt_d   = '0;
            state_d = ST_PAUSED;
            lap_d   = 1'b0;
        end else begin
            if (adj) begin
                if (adj_tick) cnt_d = adj_val;
            end else if (state_q == ST_RUN && tick_en) begin
                if (!down) begin
                    cnt_d   = up_val;
                    carry_d = all_max;
                end else if (all_zero) begin
                    state_d = ST_EXPIRED;
                end else begin
                    cnt_d = dn_val;
                    if (dn_zero) state_d = ST_EXPIRED;
                end
            end
            // A pause request decided on the pre-edge state overrides same-edge expiry
            if (pause_req) begin
                case (state_q)
                    ST_PAUSED: state_d = ST_RUN;
                    default:   state_d = ST_PAUSED;
                endcase
            end
            // Snapshot takes the pre-edge count, so a coincident tick is not shown
            if (lap_req) begin
                if (lap_q) begin
                    lap_d = 1'b0;
                end else begin
                    lap_d  = 1'b1;
                    snap_d = cnt_q;
                end
            end
        end
    end

    // State, count, snapshot and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_PAUSED;
            cnt_q   <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
            carry_q <= carry_d;
        end
    end

    assign digits     = lap_q ? snap_q : cnt_q;
    assign running    = (state_q == ST_RUN);
    assign expired    = (state_q == ST_EXPIRED);
    assign lap_active = lap_q;
    assign carry_out  = carry_q;

endmodule

// File: doc/timer_core.md
Name: timer_core

Overview:
Parameterised single-clock stopwatch/countdown core, successor to the gated-clock stopwatch datapath.
- Counts NUM_FIELDS cascaded BCD fields, each modulo FIELD_MOD, with up/down direction, per-field adjust, pause, lap freeze and countdown expiry.
- All timing comes from one-cycle enable pulses produced by the clock divider; no derived clocks.
- Sits between the debouncers/clock divider and the seven-segment display driver.

Parameters:
NUM_FIELDS, 2, number of cascaded two-digit BCD fields (field 0 least significant); range 1..8
FIELD_MOD, 60, modulus of every field; range 2..100
SEL_W, 1, width of sel; must satisfy 2**SEL_W >= NUM_FIELDS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick_en  in  1  one-cycle count-enable pulse (1 Hz)
adj_tick  in  1  one-cycle adjust-rate pulse (2 Hz)
pause_req  in  1  one-cycle debounced pulse; run/pause toggle
lap_req  in  1  one-cycle debounced pulse; lap-freeze toggle
clr  in  1  synchronous clear, level
adj  in  1  adjust mode, level
sel  in  SEL_W  field index to adjust
down  in  1  0 = count up, 1 = count down, level
digits  out  8*NUM_FIELDS  displayed BCD; field i at [8i+7:8i], tens in the upper nibble
running  out  1  state == RUN
lap_active  out  1  lap freeze engaged
expired  out  1  state == EXPIRED
carry_out  out  1  one-cycle pulse on wrap of the most significant field (up mode only)

Behaviour:
- Reset (rst=0, async): all fields 00, state PAUSED, lap_active=0, snapshot=0, carry_out=0. Outputs: digits=0, running=0, expired=0.
- State machine: PAUSED, RUN, EXPIRED.
  - pause_req: PAUSED->RUN, RUN->PAUSED, EXPIRED->PAUSED.
  - Countdown expiry: RUN->EXPIRED (see below).
- Priority per edge: clr > adjust > count > state toggles. Each uses the state and counts sampled before the edge.
- clr=1: fields 0, state PAUSED, lap_active=0, carry_out=0. Suppresses all other inputs that cycle.
- Count (state RUN, adj=0, tick_en=1):
  - Up (down=0): field0 +1; a field at FIELD_MOD-1 wraps to 0 and carries into the next field.
  - Up, all fields at FIELD_MOD-1: all wrap to 0 and carry_out=1 for exactly one cycle.
  - Down (down=1): field0 -1; a field at 0 borrows, becoming FIELD_MOD-1.
  - Down, decrement yields all-zero: count updates and state->EXPIRED on the same edge.
  - Down, tick while count already all-zero: no count change, state->EXPIRED. Never underflows.
- Adjust (adj=1):
  - tick_en is ignored.
  - On adj_tick, field[sel] steps +1 (down=0) or -1 (down=1) modulo FIELD_MOD, in any state.
  - No carry/borrow to other fields; no carry_out; state unchanged.
  - sel >= NUM_FIELDS: no change.
- EXPIRED: counting halts; only pause_req, clr or reset leave it. Adjust still allowed.
- Lap:
  - lap_req while lap_active=0: snapshot <= current count, lap_active=1.
  - lap_req while lap_active=1: lap_active=0.
  - Counting continues internally while frozen.
- digits = lap_active ? snapshot : count. Combinational select of registers, so a count update is visible the cycle after the enabling edge.
- Fields are stored in BCD. Increment/decrement handles the nibble carry internally: 09->10, 10->09. Values >= FIELD_MOD are never produced.
- Simultaneous pulses:
  - tick_en + pause_req in RUN: tick applied, then state->PAUSED.
  - tick_en + pause_req in PAUSED: no count, state->RUN.
  - lap_req + tick_en with lap off: snapshot takes the pre-increment count.

Test Plan:
- Reset release, 3 tick_en with no pause_req -> digits=0x0000, running=0. Then pause_req + 61 ticks -> digits=0x0101 (01:01).
- Up wrap: adj=1, sel=1, step field1 to 59 via 59 adj_ticks; set field0=59 likewise; adj=0, RUN, 1 tick -> digits=0x0000, carry_out high for 1 cycle.
- Countdown: adjust to 00:02, down=1, RUN, 2 ticks -> digits=0x0000, expired=1, running=0. A 3rd tick -> no change. pause_req -> expired=0, running=0.
- Adjust isolation: count 00:59, adj=1, sel=0, down=0, 1 adj_tick -> 00:00 with field1 unchanged. sel=2 (SEL_W=2) -> no change.
- Lap: at 00:10 pulse lap_req, then 5 ticks -> digits stays 0x0010. lap_req -> digits=0x0015.
- Async reset mid-count at 12:34 with lap active -> digits=0, lap_active=0 immediately, before the next clk edge. clr in the same cycle as tick_en -> 00:00, PAUSED.
